if_stage: RTL

Instruction-fetch stage of the pipelined CPU: owns the program counter and a word-addressed instruction memory, and drives `IF_instr` / `IF_pc_plus_4` into the IF/ID pipeline register every cycle. A small control FSM holds fetch idle after reset until `startin`, which allows the instruction memory to be loaded, then runs until a halt instruction is fetched. Stall and branch/jump redirect inputs come from the hazard and execute logic further down the pipeline.

---
 rtl/if_stage.sv | 96 +++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, word-addressed instruction memory
// and an IDLE/RUN/HALT control FSM feeding the IF/ID register.
module if_stage #(
  parameter int unsigned ADDR_W     = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              startin,
  input  logic              stall,
  input  logic              pc_src,
  input  logic [31:0]       branch_target,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [31:0]       imem_wdata,
  output logic [31:0]       IF_instr,
  output logic [31:0]       IF_pc_plus_4,
  output logic [31:0]       IF_pc,
  output logic              running,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  logic        in_range;
  logic [31:0] fetched;
  logic        halt_hit;

  assign in_range = (pc_q[31:ADDR_W+2] == '0);
  assign fetched  = in_range ? mem[pc_q[ADDR_W+1:2]] : '0;
  assign halt_hit = (fetched == HALT_INSTR);

  // Contents are deliberately not reset so a loaded program survives rst_n.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Redirect outranks stall, and stall defers a fetched halt word.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE: begin
        pc_d = RESET_PC;
        if (startin) state_d = S_RUN;
      end
      S_RUN: begin
        if (pc_src) begin
          pc_d = {branch_target[31:2], 2'b00};
        end else if (stall) begin
          pc_d = pc_q;
        end else if (halt_hit) begin
          state_d = S_HALT;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      S_HALT: begin
        pc_d = pc_q;
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = RESET_PC;
      end
    endcase
  end

  assign IF_pc        = pc_q;
  assign IF_pc_plus_4 = pc_q + 32'd4;
  assign IF_instr     = (state_q == S_RUN && !halt_hit) ? fetched : '0;
  assign running      = (state_q == S_RUN);
  assign halted       = (state_q == S_HALT);

endmodule
